// File: rtl/buffer_reader.sv
// buffer_reader: drain-side engine for the buffer FIFO.
// Pulls words out of the FIFO with consume strobes, catches the registered
// FIFO output one cycle later, and re-presents the words on a valid/ready
// stream through a 2-entry output stage so a steady stream needs no bubbles.
module buffer_reader #(
  parameter int WIDTH     = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 buf_empty,
  output logic                 buf_consume,
  input  logic [WIDTH-1:0]     buf_out,
  output logic [WIDTH-1:0]     dn_data,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic [CNT_WIDTH-1:0] drained_cnt,
  output logic                 idle
);

  logic [1:0]           occ_q, occ_d;
  logic                 inflight_q, inflight_d;
  logic [WIDTH-1:0]     slot0_q, slot0_d;
  logic [WIDTH-1:0]     slot1_q, slot1_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic       pop;
  logic [1:0] load;
  logic [1:0] occAfterPop;

  // Issue decision: a consume may only go out when the output stage is sure
  // to have a free slot for the word by the time it arrives next cycle.
  always_comb begin
    pop         = (occ_q != 2'd0) && dn_ready;
    load        = occ_q + {1'b0, inflight_q};
    buf_consume = !rst && !buf_empty &&
                  ((load < 2'd2) || ((load == 2'd2) && pop));
  end

  // Next-state: apply this cycle's pop first (shift slot1 into the head),
  // then drop an arriving word into the first free slot behind it.
  always_comb begin
    occAfterPop = occ_q - {1'b0, pop};
    slot0_d     = slot0_q;
    slot1_d     = slot1_q;
    if (pop) begin
      slot0_d = slot1_q;
    end
    if (inflight_q) begin
      if (occAfterPop == 2'd0) begin
        slot0_d = buf_out;
      end else begin
        slot1_d = buf_out;
      end
    end
    occ_d      = occAfterPop + {1'b0, inflight_q};
    inflight_d = buf_consume;
    cnt_d      = pop ? cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1} : cnt_q;
  end

  // State registers; reset discards held and in-flight words and the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      slot0_q    <= '0;
      slot1_q    <= '0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      cnt_q      <= cnt_d;
    end
  end

  // Stream outputs come straight from registered state.
  always_comb begin
    dn_valid    = (occ_q != 2'd0);
    dn_data     = slot0_q;
    drained_cnt = cnt_q;
    idle        = (occ_q == 2'd0) && !inflight_q && buf_empty;
  end

endmodule
